// File: rtl/regfile_write_arbiter.sv
// Purpose : arbitrates ALU / load / CSR writebacks onto two register-file write ports.
// Latency : grant is combinational; granted rd/value appear on the write ports after the granting edge.
// Backpressure: req_ready low holds a requester (stall high); rd==0 requests always drain immediately.
//
// Ports:
//   clock, reset                 single clock, asynchronous active-high reset
//   req_valid[2:0]               per-requester request (0 = ALU, 1 = load, 2 = CSR)
//   req_rd[14:0]                 5-bit destination per requester, [5i+4:5i]
//   req_value[3*XLEN-1:0]        write data per requester, [XLEN*i +: XLEN]
//   req_ready[2:0]               combinational grant
//   write_address_1/2, write_value_1/2   registered write ports (address 0 = no write)
//   stall                        some valid requester was not granted this cycle
//
// Build option: WB_ROUND_ROBIN_EN enables the rotating priority pointer; without it the
// pointer is tied to 0 and priority is fixed 0 > 1 > 2.
module regfile_write_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        req_valid,
    input  logic [14:0]       req_rd,
    input  logic [3*XLEN-1:0] req_value,
    output logic [2:0]        req_ready,
    output logic [4:0]        write_address_1,
    output logic [XLEN-1:0]   write_value_1,
    output logic [4:0]        write_address_2,
    output logic [XLEN-1:0]   write_value_2,
    output logic              stall
);

    // (base + off) mod 3 for base, off in 0..2
    function automatic logic [1:0] mod3(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    logic [1:0]      ptr;
    logic [4:0]      rd_a   [3];
    logic [XLEN-1:0] val_a  [3];
    logic [1:0]      scan_idx [3];

    logic [2:0]      grant;
    logic            p1_vld;
    logic            p2_vld;
    logic [1:0]      p1_idx;
    logic [1:0]      p2_idx;
    logic [4:0]      p1_rd;
    logic [4:0]      p2_rd;
    logic [1:0]      last_idx;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_a[i]  = req_rd[5*i +: 5];
            val_a[i] = req_value[XLEN*i +: XLEN];
        end
    end

    always_comb begin
        scan_idx[0] = ptr;
        scan_idx[1] = mod3(ptr, 2'd1);
        scan_idx[2] = mod3(ptr, 2'd2);
    end

    // Scan in priority order. rd==0 requests are acknowledged without taking a port.
    // A request colliding with port 1's rd is skipped, so a later requester with a
    // different rd can still take port 2; this also keeps the two ports distinct.
    // Only valid/rd/ptr feed this block, so ready has no path from req_value.
    always_comb begin
        grant    = 3'b000;
        p1_vld   = 1'b0;
        p2_vld   = 1'b0;
        p1_idx   = 2'd0;
        p2_idx   = 2'd0;
        p1_rd    = 5'd0;
        p2_rd    = 5'd0;
        last_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (req_valid[scan_idx[k]]) begin
                if (rd_a[scan_idx[k]] == 5'd0) begin
                    grant[scan_idx[k]] = 1'b1;
                end else if (!p1_vld) begin
                    p1_vld             = 1'b1;
                    p1_idx             = scan_idx[k];
                    p1_rd              = rd_a[scan_idx[k]];
                    grant[scan_idx[k]] = 1'b1;
                    last_idx           = scan_idx[k];
                end else if (!p2_vld && (rd_a[scan_idx[k]] != p1_rd)) begin
                    p2_vld             = 1'b1;
                    p2_idx             = scan_idx[k];
                    p2_rd              = rd_a[scan_idx[k]];
                    grant[scan_idx[k]] = 1'b1;
                    last_idx           = scan_idx[k];
                end
            end
        end
    end

    // Reset masks the grants so nothing is acknowledged (or reported stalled) in reset.
    always_comb begin
        req_ready = reset ? 3'b000 : grant;
        stall     = !reset && ((req_valid & ~grant) != 3'b000);
    end

`ifdef WB_ROUND_ROBIN_EN
    // Rotate so the requester after the last one to win a port gets first look next time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (p1_vld) begin
            ptr <= mod3(last_idx, 2'd1);
        end
    end
`else
    assign ptr = 2'd0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_address_1 <= 5'd0;
            write_value_1   <= '0;
            write_address_2 <= 5'd0;
            write_value_2   <= '0;
        end else begin
            write_address_1 <= p1_vld ? p1_rd : 5'd0;
            write_value_1   <= p1_vld ? val_a[p1_idx] : '0;
            write_address_2 <= p2_vld ? p2_rd : 5'd0;
            write_value_2   <= p2_vld ? val_a[p2_idx] : '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = 3'b000;
    logic [14:0] req_rd = 15'd0;
    logic [95:0] req_value = 96'd0;
    logic [2:0]  req_ready;
    logic [4:0]  write_address_1;
    logic [31:0] write_value_1;
    logic [4:0]  write_address_2;
    logic [31:0] write_value_2;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.XLEN(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_rd          (req_rd),
        .req_value       (req_value),
        .req_ready       (req_ready),
        .write_address_1 (write_address_1),
        .write_value_1   (write_value_1),
        .write_address_2 (write_address_2),
        .write_value_2   (write_value_2),
        .stall           (stall)
    );

    // Register-file model fed by the write ports.
    logic [31:0] rf [32];
    always @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) rf[r] <= 32'd0;
        end else begin
            if (write_address_1 != 5'd0) rf[write_address_1] <= write_value_1;
            if (write_address_2 != 5'd0) rf[write_address_2] <= write_value_2;
        end
    end

    // src = 3 means no winner on that port (address 0, value 0)
    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [2:0]  ready;
        logic        stall;
        logic [4:0]  wa1;
        logic [1:0]  src1;
        logic [4:0]  wa2;
        logic [1:0]  src2;
    } vec_t;

    vec_t        tab [12];
    logic [31:0] tval [3];

    function automatic logic [14:0] rds(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [31:0] srcval(input logic [1:0] s);
        return (s == 2'd3) ? 32'd0 : tval[s];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " rst ready"}, req_ready, 3'b000);
        chk({tag, " rst stall"}, stall, 1'b0);
        chk({tag, " rst wa1"}, write_address_1, 5'd0);
        chk({tag, " rst wa2"}, write_address_2, 5'd0);
        chk({tag, " rst wv1"}, write_value_1, 32'd0);
        chk({tag, " rst wv2"}, write_value_2, 32'd0);
    endtask

    // Enter reset at a negedge with the given request, release at the next negedge.
    task automatic reset_with(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] val);
        @(negedge clock);
        reset     = 1'b1;
        req_valid = v;
        req_rd    = rd;
        req_value = val;
        #1;
        chk_reset_state("seq");
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    logic [2:0] rr_ready [3];
    logic [4:0] rr_wa1 [3];
    logic [4:0] rr_wa2 [3];

    initial begin
        tval[0] = 32'hC0DE_0000;
        tval[1] = 32'hC0DE_0011;
        tval[2] = 32'hC0DE_0022;

        //               valid        rd               ready   stall wa1 src1 wa2 src2
        tab[0]  = '{3'b111, rds(1, 2, 3),    3'b011, 1'b1, 5'd1,  2'd0, 5'd2, 2'd1};
        tab[1]  = '{3'b000, rds(1, 2, 3),    3'b000, 1'b0, 5'd0,  2'd3, 5'd0, 2'd3};
        tab[2]  = '{3'b100, rds(0, 0, 9),    3'b100, 1'b0, 5'd9,  2'd2, 5'd0, 2'd3};
        tab[3]  = '{3'b011, rds(5, 5, 0),    3'b001, 1'b1, 5'd5,  2'd0, 5'd0, 2'd3};
        tab[4]  = '{3'b111, rds(3, 4, 0),    3'b111, 1'b0, 5'd3,  2'd0, 5'd4, 2'd1};
        tab[5]  = '{3'b111, rds(0, 0, 0),    3'b111, 1'b0, 5'd0,  2'd3, 5'd0, 2'd3};
        tab[6]  = '{3'b111, rds(6, 6, 7),    3'b101, 1'b1, 5'd6,  2'd0, 5'd7, 2'd2};
        tab[7]  = '{3'b110, rds(1, 8, 8),    3'b010, 1'b1, 5'd8,  2'd1, 5'd0, 2'd3};
        tab[8]  = '{3'b101, rds(0, 4, 4),    3'b101, 1'b0, 5'd4,  2'd2, 5'd0, 2'd3};
        tab[9]  = '{3'b010, rds(3, 0, 3),    3'b010, 1'b0, 5'd0,  2'd3, 5'd0, 2'd3};
        tab[10] = '{3'b111, rds(10, 10, 10), 3'b001, 1'b1, 5'd10, 2'd0, 5'd0, 2'd3};
        tab[11] = '{3'b110, rds(2, 0, 12),   3'b110, 1'b0, 5'd12, 2'd2, 5'd0, 2'd3};

        // Each vector starts from reset so the pointer is 0 regardless of build.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            reset     = 1'b1;
            req_valid = tab[i].valid;
            req_rd    = tab[i].rd;
            req_value = {tval[2], tval[1], tval[0]};
            #1;
            chk($sformatf("v%0d rst ready", i), req_ready, 3'b000);
            chk($sformatf("v%0d rst wa1", i), write_address_1, 5'd0);
            chk($sformatf("v%0d rst stall", i), stall, 1'b0);
            @(negedge clock);
            reset = 1'b0;
            #1;
            chk($sformatf("v%0d ready", i), req_ready, tab[i].ready);
            chk($sformatf("v%0d stall", i), stall, tab[i].stall);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d wa1", i), write_address_1, tab[i].wa1);
            chk($sformatf("v%0d wv1", i), write_value_1, srcval(tab[i].src1));
            chk($sformatf("v%0d wa2", i), write_address_2, tab[i].wa2);
            chk($sformatf("v%0d wv2", i), write_value_2, srcval(tab[i].src2));
        end

        // Same-rd collision: req1 is held and wins the following cycle.
        reset_with(3'b011, rds(5, 5, 0), {32'h0, 32'hB, 32'hA});
        chk("coll ready1", req_ready, 3'b001);
        @(posedge clock);
        #1;
        chk("coll wa1", write_address_1, 5'd5);
        chk("coll wv1", write_value_1, 32'hA);
        chk("coll wa2", write_address_2, 5'd0);
        @(negedge clock);
        req_valid = 3'b010;
        #1;
        chk("coll ready2", req_ready, 3'b010);
        chk("coll stall2", stall, 1'b0);
        @(posedge clock);
        #1;
        chk("coll2 wa1", write_address_1, 5'd5);
        chk("coll2 wv1", write_value_1, 32'hB);

        // Continuous contention from all three with distinct rd.
        rr_ready[0] = 3'b011; rr_wa1[0] = 5'd1; rr_wa2[0] = 5'd2;
        rr_ready[1] = 3'b101; rr_wa1[1] = 5'd3; rr_wa2[1] = 5'd1;
        rr_ready[2] = 3'b110; rr_wa1[2] = 5'd2; rr_wa2[2] = 5'd3;
        reset_with(3'b111, rds(1, 2, 3), {tval[2], tval[1], tval[0]});
        for (int c = 0; c < 6; c++) begin
`ifdef WB_ROUND_ROBIN_EN
            chk($sformatf("rr%0d ready", c), req_ready, rr_ready[c % 3]);
            chk($sformatf("rr%0d stall", c), stall, 1'b1);
            @(posedge clock);
            #1;
            chk($sformatf("rr%0d wa1", c), write_address_1, rr_wa1[c % 3]);
            chk($sformatf("rr%0d wa2", c), write_address_2, rr_wa2[c % 3]);
`else
            chk($sformatf("fix%0d ready", c), req_ready, 3'b011);
            chk($sformatf("fix%0d stall", c), stall, 1'b1);
            @(posedge clock);
            #1;
            chk($sformatf("fix%0d wa1", c), write_address_1, 5'd1);
            chk($sformatf("fix%0d wa2", c), write_address_2, 5'd2);
`endif
            @(negedge clock);
            #1;
        end

        // Write latency into the register file.
        reset_with(3'b010, rds(0, 7, 0), {32'h0, 32'h1234, 32'h0});
        chk("lat ready", req_ready, 3'b010);
        @(posedge clock);
        #1;
        chk("lat wa1", write_address_1, 5'd7);
        chk("lat wv1", write_value_1, 32'h1234);
        chk("lat rf early", rf[7], 32'd0);
        @(negedge clock);
        req_valid = 3'b000;
        @(posedge clock);
        #1;
        chk("lat rf7", rf[7], 32'h1234);
        chk("lat wa1 idle", write_address_1, 5'd0);

        // Reset in mid-operation drops the in-flight grant and restarts at ptr 0.
        reset_with(3'b111, rds(1, 2, 3), {tval[2], tval[1], tval[0]});
        @(posedge clock);
        #1;
        chk("mid wa1 pre", write_address_1, 5'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("mid");
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid ready", req_ready, 3'b011);
        @(posedge clock);
        #1;
        chk("mid wa1", write_address_1, 5'd1);
        chk("mid wa2", write_address_2, 5'd2);
        chk("mid wv2", write_value_2, tval[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
